bist_sequencer: RTL and testbench
=================================

# bist_sequencer

Session sequencer for the scan-based BIST datapath. On request it seeds the input LFSR, clears the signature MISR, then alternates scan-shift and capture phases for a fixed number of patterns, flushes the last response, and raises the compare strobe and end-of-test flag. It replaces ad-hoc scan-enable generation: its outputs drive the circuit-under-test scan enable and input mux, the LFSR seed load, the MISR enable/clear and the comparator strobe.

## Interface
- CHAIN_LEN, 8: scan chain length in flops; shift phase length in cycles; ≥1
- N_PATTERNS, 16: capture cycles per session; ≥1
- CNT_W, 8: width of internal counters and PATTERN_IDX; must hold max(CHAIN_LEN, N_PATTERNS)
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  session request, level; sampled only in IDLE and DONE
- ABORT  in  1  cancel session, level
- SCAN_EN  out  1  scan enable to CUT; also selects LFSR inputs at CUT mux
- SEED  out  1  one-cycle LFSR seed-load pulse
- MISR_CLR  out  1  one-cycle MISR clear pulse
- MISR_EN  out  1  MISR compaction enable
- RUNNING  out  1  session in progress
- FINISH  out  1  one-cycle comparator strobe
- BIST_END  out  1  session complete, level
- PATTERN_IDX  out  CNT_W  captures completed in current session

## Operation
- States: IDLE, INIT, SHIFT, CAPTURE, FLUSH, DONE. All outputs decoded from registered state/counters; no combinational input-to-output path.
- IDLE: all outputs 0. START=1 and ABORT=0 -> INIT; PATTERN_IDX cleared to 0.
- INIT (1 cycle): SEED=1, MISR_CLR=1, RUNNING=1. -> SHIFT, shift counter = 0.
- SHIFT: SCAN_EN=1, MISR_EN=1, RUNNING=1. Shift counter increments each cycle; after CHAIN_LEN cycles -> CAPTURE.
- CAPTURE (1 cycle): SCAN_EN=0, MISR_EN=1, RUNNING=1. PATTERN_IDX increments on exit. If new PATTERN_IDX == N_PATTERNS -> FLUSH, else -> SHIFT (counter reset).
- FLUSH: as SHIFT, CHAIN_LEN cycles, unloads last response; -> DONE.
- DONE: BIST_END=1, RUNNING=0, SCAN_EN=0, MISR_EN=0. FINISH=1 only in first DONE cycle. Stays while START=1; START=0 -> IDLE. PATTERN_IDX holds N_PATTERNS until next INIT.
- ABORT=1 in any state except IDLE -> IDLE on next edge; no FINISH, BIST_END stays 0; PATTERN_IDX holds last value.
- START and ABORT both 1 in IDLE: ABORT wins, remain IDLE.
- START re-asserted/held during INIT..FLUSH: ignored.
- Counters saturate never wrap within a session; PATTERN_IDX never exceeds N_PATTERNS.

## Timing
- Reset: state IDLE; SCAN_EN, SEED, MISR_CLR, MISR_EN, RUNNING, FINISH, BIST_END = 0; PATTERN_IDX = 0. RST mid-session takes effect on next edge, overrides ABORT/START.
- Edge E0 samples START in IDLE: INIT occupies cycle after E0; SHIFT begins after E0+1.
- Session length: DONE entered at edge E0 + 1 + N_PATTERNS·(CHAIN_LEN+1) + CHAIN_LEN; defaults: E0+153.
- SCAN_EN high cycles per session: (N_PATTERNS+1)·CHAIN_LEN; defaults 136. MISR_EN high cycles: that plus N_PATTERNS; defaults 152.
- FINISH coincides with first BIST_END=1 cycle; MISR has absorbed final flush bit on that edge.
- DONE -> IDLE one edge after START sampled 0; new session needs START high in IDLE (min 1 cycle low between sessions).

## Test plan
- Reset: hold RST 2 cycles with START=1 -> all outputs 0, state IDLE; release with START=0 -> stays IDLE.
- Full session defaults: pulse START high, keep high -> SEED and MISR_CLR high exactly 1 cycle, SCAN_EN high 136 cycles in 17 runs of 8 separated by single low cycles, BIST_END rises 153 edges after START sampled, FINISH high 1 cycle, PATTERN_IDX = 16.
- Return/restart: drop START in DONE -> IDLE next edge, BIST_END=0; reassert -> second session identical cycle counts, PATTERN_IDX restarts at 0.
- Abort: ABORT=1 during pattern 5 SHIFT -> IDLE next edge, SCAN_EN/MISR_EN/RUNNING 0, FINISH never pulses, PATTERN_IDX = 4 held.
- Reset mid-FLUSH: RST=1 -> all outputs 0 next edge, PATTERN_IDX = 0.
- Boundary parameters CHAIN_LEN=1, N_PATTERNS=1: START -> BIST_END after 1+2+1 = 4 edges, SCAN_EN pattern 1,0,1; START+ABORT together in IDLE -> no INIT.

Source files
------------

// File: rtl/bist_sequencer.sv
// ---------------------------------------------------------------------------
// bist_sequencer
//
// Session sequencer for the scan-based BIST datapath. A session starts on a
// request. It seeds the input LFSR and clears the signature MISR. It then
// alternates scan-shift and capture phases for N_PATTERNS patterns. After
// that it flushes the last response out of the chain. Finally it strobes
// the comparator and flags end-of-test.
//
// Every output is decoded from registered state and counters only, so no
// input reaches an output through combinational logic.
//
// Parameters:
//   CHAIN_LEN   scan chain length in flops, which is also the shift phase length (>=1)
//   N_PATTERNS  number of capture cycles per session (>=1)
//   CNT_W       counter width; must hold max(CHAIN_LEN, N_PATTERNS)
//
// Ports:
//   clk          system clock; all state updates on the rising edge
//   rst          synchronous active-high reset
//   start        session request (level); looked at only in IDLE and DONE
//   abort        cancels a running or finished session (level)
//   scan_en      scan enable to the CUT; also selects LFSR data at the CUT mux
//   seed         one-cycle LFSR seed-load pulse
//   misr_clr     one-cycle MISR clear pulse
//   misr_en      MISR compaction enable
//   running      session in progress
//   finish       one-cycle comparator strobe on the first DONE cycle
//   bist_end     session complete (level)
//   pattern_idx  number of captures completed in the current session
// ---------------------------------------------------------------------------
module bist_sequencer #(
    parameter int CHAIN_LEN  = 8,
    parameter int N_PATTERNS = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             scan_en,
    output logic             seed,
    output logic             misr_clr,
    output logic             misr_en,
    output logic             running,
    output logic             finish,
    output logic             bist_end,
    output logic [CNT_W-1:0] pattern_idx
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHIFT,
        CAPTURE,
        FLUSH,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] PAT_TOTAL  = CNT_W'(N_PATTERNS);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] shift_cnt;
    logic [CNT_W-1:0] pat_cnt;
    logic             done_seen;
    logic             shift_done;

    // The last shift cycle of a SHIFT or FLUSH phase.
    assign shift_done = (shift_cnt == SHIFT_LAST);

    // Next-state logic. The abort check comes last so that it overrides
    // every other transition. In IDLE, abort only stops a new session from
    // starting.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                if (shift_done) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                // Decide using the count as it will be after this capture.
                if ((pat_cnt + CNT_W'(1)) == PAT_TOTAL) begin
                    state_next = FLUSH;
                end else begin
                    state_next = SHIFT;
                end
            end
            FLUSH: begin
                if (shift_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
        end
    end

    // State register and counters.
    // The shift counter restarts on every entry into a shift-type phase. It
    // also stops at the last position instead of wrapping around.
    // The pattern count is cleared only when a new session starts. It
    // advances when a capture completes normally, so an abort leaves it at
    // the last completed value.
    // done_seen marks every DONE cycle after the first one. This keeps the
    // finish strobe to a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            done_seen <= 1'b0;
        end else begin
            state     <= state_next;
            done_seen <= (state == DONE);

            if (((state == SHIFT) || (state == FLUSH)) && (state_next == state)) begin
                if (!shift_done) begin
                    shift_cnt <= shift_cnt + CNT_W'(1);
                end
            end else begin
                shift_cnt <= '0;
            end

            if ((state == IDLE) && (state_next == INIT)) begin
                pat_cnt <= '0;
            end else if ((state == CAPTURE) && (state_next != IDLE) && (pat_cnt != PAT_TOTAL)) begin
                pat_cnt <= pat_cnt + CNT_W'(1);
            end
        end
    end

    // Output decode from the registered state.
    always_comb begin
        scan_en  = 1'b0;
        seed     = 1'b0;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        running  = 1'b0;
        finish   = 1'b0;
        bist_end = 1'b0;
        case (state)
            INIT: begin
                seed     = 1'b1;
                misr_clr = 1'b1;
                running  = 1'b1;
            end
            SHIFT, FLUSH: begin
                scan_en = 1'b1;
                misr_en = 1'b1;
                running = 1'b1;
            end
            CAPTURE: begin
                misr_en = 1'b1;
                running = 1'b1;
            end
            DONE: begin
                bist_end = 1'b1;
                finish   = !done_seen;
            end
            default: begin
            end
        endcase
    end

    assign pattern_idx = pat_cnt;

endmodule

// File: tb/tb_bist_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bist_sequencer
//
// Drives two sequencers from one set of stimulus inputs:
//   - instance A uses the default parameters (8, 16);
//   - instance B uses the boundary parameters (1, 1).
//
// Expected outputs come from a timeline model. The model tracks how many
// cycles have passed since INIT and derives the phase arithmetically.
// Each expected vector is queued when its stimulus is driven. It is then
// popped and compared one time unit after the active edge.
// ---------------------------------------------------------------------------
module tb_bist_sequencer;

    localparam int CNT_W = 8;
    localparam int CL_A  = 8;
    localparam int NP_A  = 16;
    localparam int CL_B  = 1;
    localparam int NP_B  = 1;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;

    logic             scan_en_a, seed_a, misr_clr_a, misr_en_a, running_a, finish_a, bist_end_a;
    logic [CNT_W-1:0] idx_a;
    logic             scan_en_b, seed_b, misr_clr_b, misr_en_b, running_b, finish_b, bist_end_b;
    logic [CNT_W-1:0] idx_b;

    bist_sequencer #(.CHAIN_LEN(CL_A), .N_PATTERNS(NP_A), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .scan_en(scan_en_a), .seed(seed_a), .misr_clr(misr_clr_a), .misr_en(misr_en_a),
        .running(running_a), .finish(finish_a), .bist_end(bist_end_a), .pattern_idx(idx_a)
    );

    bist_sequencer #(.CHAIN_LEN(CL_B), .N_PATTERNS(NP_B), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .scan_en(scan_en_b), .seed(seed_b), .misr_clr(misr_clr_b), .misr_en(misr_en_b),
        .running(running_b), .finish(finish_b), .bist_end(bist_end_b), .pattern_idx(idx_b)
    );

    always #5 clk = ~clk;

    int vecCount  = 0;
    int missCount = 0;

    // Model state per instance.
    // mMode: 0 = idle, 1 = active (INIT through FLUSH), 2 = done.
    int mMode [2] = '{0, 0};
    int mT    [2] = '{0, 0};
    int mHeld [2] = '{0, 0};
    bit mFirst[2] = '{0, 0};
    int mCl   [2] = '{CL_A, CL_B};
    int mNp   [2] = '{NP_A, NP_B};

    logic [14:0] expQ[$];

    // Statistics for instance A over one session.
    int cycleNo, scanCnt, misrCnt, seedCnt, clrCnt, finCnt, endCycle;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Captures completed at the current point of an active session.
    function automatic int modelIdx(int k);
        int u;
        if (mT[k] == 0) return 0;
        u = mT[k] - 1;
        if (u < mNp[k] * (mCl[k] + 1)) return u / (mCl[k] + 1);
        return mNp[k];
    endfunction

    // Expected output vector:
    // {scan_en, seed, misr_clr, misr_en, running, finish, bist_end, idx}.
    function automatic logic [14:0] modelOut(int k);
        bit se, sd, mc, me, rn, fi, be;
        int idx, u, r;
        se = 0; sd = 0; mc = 0; me = 0; rn = 0; fi = 0; be = 0;
        idx = mHeld[k];
        if (mMode[k] == 2) begin
            be  = 1;
            fi  = mFirst[k];
            idx = mNp[k];
        end else if (mMode[k] == 1) begin
            rn  = 1;
            idx = modelIdx(k);
            if (mT[k] == 0) begin
                sd = 1;
                mc = 1;
            end else begin
                u  = mT[k] - 1;
                me = 1;
                if (u < mNp[k] * (mCl[k] + 1)) begin
                    r  = u % (mCl[k] + 1);
                    se = (r < mCl[k]);
                end else begin
                    se = 1;
                end
            end
        end
        return {se, sd, mc, me, rn, fi, be, idx[7:0]};
    endfunction

    task automatic modelStep(int k, bit st, bit ab, bit rs);
        if (rs) begin
            mMode[k] = 0;
            mHeld[k] = 0;
        end else begin
            case (mMode[k])
                0: if (st && !ab) begin
                    mMode[k] = 1;
                    mT[k]    = 0;
                    mHeld[k] = 0;
                end
                1: if (ab) begin
                    mHeld[k] = modelIdx(k);
                    mMode[k] = 0;
                end else begin
                    mT[k]++;
                    if (mT[k] == 1 + mNp[k] * (mCl[k] + 1) + mCl[k]) begin
                        mMode[k]  = 2;
                        mFirst[k] = 1;
                    end
                end
                default: if (ab || !st) begin
                    mMode[k] = 0;
                    mHeld[k] = mNp[k];
                end else begin
                    mFirst[k] = 0;
                end
            endcase
        end
    endtask

    // One clock cycle:
    // 1. drive the inputs;
    // 2. queue the expected vectors;
    // 3. compare after the edge.
    task automatic applyStimulus(input bit st, input bit ab, input bit rs);
        @(negedge clk);
        start = st;
        abort = ab;
        rst   = rs;
        for (int k = 0; k < 2; k++) begin
            modelStep(k, st, ab, rs);
            expQ.push_back(modelOut(k));
        end
        @(posedge clk);
        #1;
        checkOutput("outA", 32'({scan_en_a, seed_a, misr_clr_a, misr_en_a, running_a,
                                 finish_a, bist_end_a, idx_a}), 32'(expQ.pop_front()));
        checkOutput("outB", 32'({scan_en_b, seed_b, misr_clr_b, misr_en_b, running_b,
                                 finish_b, bist_end_b, idx_b}), 32'(expQ.pop_front()));
        cycleNo++;
        if (scan_en_a)  scanCnt++;
        if (misr_en_a)  misrCnt++;
        if (seed_a)     seedCnt++;
        if (misr_clr_a) clrCnt++;
        if (finish_a)   finCnt++;
        if (bist_end_a && endCycle == 0) endCycle = cycleNo;
    endtask

    task automatic clearStats();
        cycleNo = 0; scanCnt = 0; misrCnt = 0; seedCnt = 0;
        clrCnt = 0; finCnt = 0; endCycle = 0;
    endtask

    // Runs one full default-parameter session with start held high, then
    // checks the per-session cycle counts of instance A.
    task automatic fullSession();
        clearStats();
        for (int i = 0; i < 160; i++) applyStimulus(1, 0, 0);
        checkOutput("scanCycles", 32'(scanCnt),  32'((NP_A + 1) * CL_A));
        checkOutput("misrCycles", 32'(misrCnt),  32'((NP_A + 1) * CL_A + NP_A));
        checkOutput("seedCycles", 32'(seedCnt),  32'd1);
        checkOutput("clrCycles",  32'(clrCnt),   32'd1);
        checkOutput("finCycles",  32'(finCnt),   32'd1);
        checkOutput("endEdge",    32'(endCycle), 32'(2 + NP_A * (CL_A + 1) + CL_A));
        checkOutput("idxDone",    32'(idx_a),    32'(NP_A));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b0;

        // Reset held with start high, then released with start low.
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);

        // First session, return to IDLE, then a second identical session.
        fullSession();
        applyStimulus(0, 0, 0);
        checkOutput("idleEnd", 32'(bist_end_a), 32'd0);
        applyStimulus(0, 0, 0);
        fullSession();
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0);

        // Abort during the shift phase of pattern 5.
        for (int i = 0; i < 41; i++) applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        checkOutput("abortIdx", 32'(idx_a), 32'd4);

        // Start and abort together while idle: no INIT.
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0);

        // Reset during FLUSH, which overrides both start and abort.
        for (int i = 0; i < 149; i++) applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0);

        // Random traffic with occasional abort and reset.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 40) == 0,
                          $urandom_range(0, 150) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
